// File: rtl/bcd_timer.sv
// N-digit BCD game-clock timer: per-digit mod-10/mod-6 counting up or down on a tick,
// with load/start/pause control and finish reporting.
module bcd_timer #(
  parameter int unsigned        NDIGITS     = 4,
  parameter logic [NDIGITS-1:0] MOD6_MASK   = NDIGITS'(4'b1010),
  parameter bit                 AUTO_RELOAD = 1'b0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   tick,
  input  logic                   dir,
  input  logic                   load,
  input  logic [NDIGITS*4-1:0]   load_value,
  input  logic                   start,
  input  logic                   pause,
  output logic [NDIGITS*4-1:0]   bcd,
  output logic                   running,
  output logic                   finished,
  output logic                   finish_pulse
);

  localparam int unsigned W = NDIGITS * 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_PAUSED,
    ST_DONE
  } state_e;

  function automatic logic [W-1:0] max_pattern();
    logic [W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < NDIGITS; i++) begin
      r[4*i +: 4] = MOD6_MASK[i] ? 4'd5 : 4'd9;
    end
    return r;
  endfunction

  localparam logic [W-1:0] MAX_VAL = max_pattern();

  state_e         state_q, state_d;
  logic [W-1:0]   bcd_q, bcd_d;
  logic [W-1:0]   preset_q, preset_d;
  logic           dir_q, dir_d;
  logic           running_q, running_d;
  logic           finished_q, finished_d;
  logic           finish_pulse_q, finish_pulse_d;

  logic [W-1:0]   clamp_val, dec_val, inc_val;
  logic [W-1:0]   start_val, next_val;
  logic           fire;

  // Per-digit clamp and borrow/carry chains for the mixed-radix count.
  always_comb begin
    logic       borrow;
    logic       carry;
    logic [3:0] dmax;
    logic [3:0] cur;
    logic [3:0] lv;
    borrow    = 1'b1;
    carry     = 1'b1;
    clamp_val = '0;
    dec_val   = '0;
    inc_val   = '0;
    dmax      = 4'd0;
    cur       = 4'd0;
    lv        = 4'd0;
    for (int unsigned i = 0; i < NDIGITS; i++) begin
      dmax = MAX_VAL[4*i +: 4];
      cur  = bcd_q[4*i +: 4];
      lv   = load_value[4*i +: 4];
      clamp_val[4*i +: 4] = (lv > dmax) ? dmax : lv;
      dec_val[4*i +: 4]   = borrow ? ((cur == 4'd0) ? dmax : cur - 4'd1) : cur;
      inc_val[4*i +: 4]   = carry ? ((cur == dmax) ? 4'd0 : cur + 4'd1) : cur;
      borrow = borrow && (cur == 4'd0);
      carry  = carry && (cur == dmax);
    end
  end

  // Command decode in priority order: load, pause, start, tick.
  always_comb begin
    state_d   = state_q;
    bcd_d     = bcd_q;
    preset_d  = preset_q;
    dir_d     = dir_q;
    start_val = (state_q == ST_DONE) ? preset_q : bcd_q;
    next_val  = dir_q ? inc_val : dec_val;
    fire      = 1'b0;

    if (AUTO_RELOAD && !dir_q && (bcd_q == '0)) begin
      next_val = preset_q;
    end

    if (load) begin
      bcd_d    = clamp_val;
      preset_d = clamp_val;
      state_d  = ST_IDLE;
    end else if (pause) begin
      if (state_q == ST_RUN) begin
        state_d = ST_PAUSED;
      end
    end else if (start && (state_q != ST_RUN)) begin
      dir_d = dir;
      bcd_d = start_val;
      if (!dir && (start_val == '0)) begin
        state_d = ST_DONE;
        fire    = 1'b1;
      end else begin
        state_d = ST_RUN;
      end
    end else if (tick && (state_q == ST_RUN)) begin
      bcd_d = next_val;
      if (dir_q ? (next_val == MAX_VAL) : (next_val == '0)) begin
        fire = 1'b1;
        if (!AUTO_RELOAD) begin
          state_d = ST_DONE;
        end
      end
    end

    // A pulse directly after another is suppressed so it never stretches.
    finish_pulse_d = fire && !finish_pulse_q;
    running_d      = (state_d == ST_RUN);
    finished_d     = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      bcd_q          <= '0;
      preset_q       <= '0;
      dir_q          <= 1'b0;
      running_q      <= 1'b0;
      finished_q     <= 1'b0;
      finish_pulse_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      bcd_q          <= bcd_d;
      preset_q       <= preset_d;
      dir_q          <= dir_d;
      running_q      <= running_d;
      finished_q     <= finished_d;
      finish_pulse_q <= finish_pulse_d;
    end
  end

  assign bcd          = bcd_q;
  assign running      = running_q;
  assign finished     = finished_q;
  assign finish_pulse = finish_pulse_q;

endmodule
